// File: rtl/pcu_pkg.sv
// -----------------------------------------------------------------------------
// pcu_pkg
// Shared types and constants for the six-instruction processor control unit.
//   - state_e  : FSM states; the 4-bit encodings appear on OutState for debug.
//   - opcode_e : IR[15:12] opcodes.
//   - ALU_*    : ALU_s0 select codes understood by the datapath.
//   - IR_*     : bit positions of the instruction fields.
//   - decode_next() : maps an opcode to the execute state entered from Decode.
// Optional feature macro: PCU_ILLEGAL_TRAP_EN. When it is defined, illegal
// opcodes trap into ST_ILLEGAL. When it is undefined, they execute as NOOP.
// -----------------------------------------------------------------------------
package pcu_pkg;

    typedef enum logic [3:0] {
        ST_INIT    = 4'h0,
        ST_FETCH   = 4'h1,
        ST_DECODE  = 4'h2,
        ST_NOOP    = 4'h3,
        ST_STORE   = 4'h4,
        ST_LOADA   = 4'h5,
        ST_LOADB   = 4'h6,
        ST_ADD     = 4'h7,
        ST_SUB     = 4'h8,
        ST_HALT    = 4'h9
`ifdef PCU_ILLEGAL_TRAP_EN
        ,
        ST_ILLEGAL = 4'hF
`endif
    } state_e;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_e;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // Instruction field positions.
    localparam int IR_OP_HI   = 15;
    localparam int IR_OP_LO   = 12;
    localparam int IR_RD_HI   = 11;  // destination / STORE source / LOAD target
    localparam int IR_RD_LO   = 8;
    localparam int IR_ADDR_HI = 7;   // 8-bit data-memory address
    localparam int IR_ADDR_LO = 0;
    localparam int IR_RA_HI   = 7;   // ALU operand A register
    localparam int IR_RA_LO   = 4;
    localparam int IR_RB_HI   = 3;   // ALU operand B register
    localparam int IR_RB_LO   = 0;

    // Execute state that follows Decode for a given opcode.
    function automatic state_e decode_next(input logic [3:0] op);
        case (opcode_e'(op))
            OP_NOOP:  return ST_NOOP;
            OP_STORE: return ST_STORE;
            OP_LOAD:  return ST_LOADA;
            OP_ADD:   return ST_ADD;
            OP_SUB:   return ST_SUB;
            OP_HALT:  return ST_HALT;
`ifdef PCU_ILLEGAL_TRAP_EN
            default:  return ST_ILLEGAL;
`else
            default:  return ST_NOOP;
`endif
        endcase
    endfunction

endpackage

// File: rtl/pcu_program_counter.sv
// -----------------------------------------------------------------------------
// pcu_program_counter
// Program counter register for the control unit. A synchronous clear returns
// the counter to 0. An increment adds 1 and wraps silently at 2**PC_W.
// Ports:
//   clk_i  in   clock, rising edge
//   clr_i  in   synchronous clear, active high (takes priority over inc_i)
//   inc_i  in   advance the counter by one
//   pc_o   out  current program counter (registered)
// -----------------------------------------------------------------------------
module pcu_program_counter #(
    parameter int PC_W = 7
) (
    input  logic            clk_i,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Modulo addition gives the 127 -> 0 wrap without any extra logic.
    always_comb begin
        pc_d = pc_q;
        if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and simulation matches hardware.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/pcontrol_unit.sv
// -----------------------------------------------------------------------------
// pcontrol_unit
// Moore control unit for the six-instruction 16-bit processor. The unit fetches
// from the instruction ROM, latches the instruction in IR, decodes the opcode,
// and drives the PDataPath control inputs for a fixed number of cycles for
// each instruction.
// Ports:
//   Clock       in   system clock, rising edge
//   Reset       in   synchronous active-high reset
//   Instr       in   ROM read data (combinational in PC_Out)
//   PC_Out      out  ROM address
//   I_rd        out  ROM read strobe (Fetch only)
//   IR_Out      out  instruction register
//   D_addr      out  data-memory address
//   D_wr        out  data-memory write enable
//   RF_s        out  write-back select (1 = memory, 0 = ALU)
//   RF_W_addr   out  register-file write address
//   RF_W_en     out  register-file write enable
//   RF_Ra_addr  out  register-file read address A
//   RF_Rb_addr  out  register-file read address B
//   ALU_s0      out  ALU select
//   OutState    out  current state encoding (debug)
// Optional feature macro: PCU_ILLEGAL_TRAP_EN (illegal opcodes trap into the
// Illegal state, which reads 4'hF on OutState).
// -----------------------------------------------------------------------------
module pcontrol_unit
    import pcu_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [15:0]     Instr,
    output logic [PC_W-1:0] PC_Out,
    output logic            I_rd,
    output logic [15:0]     IR_Out,
    output logic [7:0]      D_addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      ALU_s0,
    output logic [3:0]      OutState
);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] ir_q;
    logic [15:0] ir_d;
    logic        pc_inc;

    // The PC advances only on the Fetch edge, so it holds steady from Decode
    // until the next Fetch.
    assign pc_inc = (state_q == ST_FETCH);

    pcu_program_counter #(
        .PC_W (PC_W)
    ) u_pc (
        .clk_i (Clock),
        .clr_i (Reset),
        .inc_i (pc_inc),
        .pc_o  (PC_Out)
    );

    assign ir_d = (state_q == ST_FETCH) ? Instr : ir_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic and Moore output decode. The outputs depend only on
    // state_q and ir_q, so an enable that is high in the cycle of a reset edge
    // still acts at that edge.
    always_comb begin
        // NOTE: every output gets its default before the case statement, so
        // no path leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        I_rd       = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = ALU_PASS;

        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                I_rd    = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = decode_next(ir_q[IR_OP_HI:IR_OP_LO]);
            end
            ST_NOOP: begin
                state_d = ST_FETCH;
            end
            ST_STORE: begin
                D_addr     = ir_q[IR_ADDR_HI:IR_ADDR_LO];
                RF_Ra_addr = ir_q[IR_RD_HI:IR_RD_LO];
                D_wr       = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_LOADA: begin
                // The memory read is synchronous, so this cycle only presents
                // the address. The data is written back in LoadB.
                D_addr  = ir_q[IR_ADDR_HI:IR_ADDR_LO];
                state_d = ST_LOADB;
            end
            ST_LOADB: begin
                D_addr    = ir_q[IR_ADDR_HI:IR_ADDR_LO];
                RF_s      = 1'b1;
                RF_W_addr = ir_q[IR_RD_HI:IR_RD_LO];
                RF_W_en   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_ADD, ST_SUB: begin
                RF_Ra_addr = ir_q[IR_RA_HI:IR_RA_LO];
                RF_Rb_addr = ir_q[IR_RB_HI:IR_RB_LO];
                RF_W_addr  = ir_q[IR_RD_HI:IR_RD_LO];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
`ifdef PCU_ILLEGAL_TRAP_EN
            ST_ILLEGAL: begin
                state_d = ST_ILLEGAL;
            end
`endif
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign IR_Out   = ir_q;
    assign OutState = state_q;

endmodule

// File: tb/tb_pcontrol_unit.sv
// -----------------------------------------------------------------------------
// tb_pcontrol_unit
// Self-checking bench for pcontrol_unit. A behavioural ROM feeds Instr from
// PC_Out. Outputs are sampled on the falling edge. A cycle-by-cycle table
// covers a mixed program (ADD, LOAD, STORE, SUB, NOOP, HALT). Hand-written
// sequences cover the Halt hold, the PC wrap, a reset during Store, and an
// illegal opcode.
// -----------------------------------------------------------------------------
module tb_pcontrol_unit;

    logic        Clock;
    logic        Reset;
    logic [15:0] Instr;
    logic [6:0]  PC_Out;
    logic        I_rd;
    logic [15:0] IR_Out;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  OutState;

    logic [15:0] rom [128];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  pc;
        logic        i_rd;
        logic [15:0] ir;
        logic [7:0]  da;
        logic        dwr;
        logic        rfs;
        logic [3:0]  wa;
        logic        wen;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } vec_t;

    vec_t vecs [20];

    pcontrol_unit #(.PC_W(7)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Instr      (Instr),
        .PC_Out     (PC_Out),
        .I_rd       (I_rd),
        .IR_Out     (IR_Out),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .OutState   (OutState)
    );

    assign Instr = rom[PC_Out];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic obs_t mk(input logic [3:0] st, input logic [6:0] pc,
                                input logic i_rd, input logic [15:0] ir,
                                input logic [7:0] da, input logic dwr,
                                input logic rfs, input logic [3:0] wa,
                                input logic wen, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [2:0] alu);
        obs_t o;
        o = '{st, pc, i_rd, ir, da, dwr, rfs, wa, wen, ra, rb, alu};
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(OutState, PC_Out, I_rd, IR_Out, D_addr, D_wr, RF_s,
                  RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    // Assert Reset for two rising edges and release it on a falling edge.
    // On return the DUT is in Init.
    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Wait, sampling on falling edges, until OutState equals s.
    task automatic wait_state(input logic [3:0] s, input int budget,
                              output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (OutState == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin : main
        bit   ok;
        int   wr_seen;
        obs_t halt_exp;

        Reset = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;

        // ---------------- table-driven mixed program ----------------
        rom[0] = 16'h3312;  // ADD  R3 <= R1 + R2
        rom[1] = 16'h2505;  // LOAD R5 <= D[05]
        rom[2] = 16'h1A80;  // STORE D[80] <= RA
        rom[3] = 16'h4721;  // SUB  R7 <= R2 - R1
        rom[4] = 16'h0000;  // NOOP
        rom[5] = 16'h5000;  // HALT

        //                           st    pc  rd  ir        da     w  s  wa  we ra  rb  alu
        vecs[0]  = '{"init",    mk(4'h0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[1]  = '{"fetch0",  mk(4'h1, 0, 1, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[2]  = '{"dec_add", mk(4'h2, 1, 0, 16'h3312, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[3]  = '{"add",     mk(4'h7, 1, 0, 16'h3312, 8'h00, 0, 0, 3, 1, 1, 2, 3'd1)};
        vecs[4]  = '{"fetch1",  mk(4'h1, 1, 1, 16'h3312, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[5]  = '{"dec_ld",  mk(4'h2, 2, 0, 16'h2505, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[6]  = '{"loada",   mk(4'h5, 2, 0, 16'h2505, 8'h05, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[7]  = '{"loadb",   mk(4'h6, 2, 0, 16'h2505, 8'h05, 0, 1, 5, 1, 0, 0, 3'd0)};
        vecs[8]  = '{"fetch2",  mk(4'h1, 2, 1, 16'h2505, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[9]  = '{"dec_st",  mk(4'h2, 3, 0, 16'h1A80, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[10] = '{"store",   mk(4'h4, 3, 0, 16'h1A80, 8'h80, 1, 0, 0, 0, 4'hA, 0, 3'd0)};
        vecs[11] = '{"fetch3",  mk(4'h1, 3, 1, 16'h1A80, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[12] = '{"dec_sub", mk(4'h2, 4, 0, 16'h4721, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[13] = '{"sub",     mk(4'h8, 4, 0, 16'h4721, 8'h00, 0, 0, 7, 1, 2, 1, 3'd2)};
        vecs[14] = '{"fetch4",  mk(4'h1, 4, 1, 16'h4721, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[15] = '{"dec_nop", mk(4'h2, 5, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[16] = '{"noop",    mk(4'h3, 5, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[17] = '{"fetch5",  mk(4'h1, 5, 1, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[18] = '{"dec_hlt", mk(4'h2, 6, 0, 16'h5000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[19] = '{"halt",    mk(4'h9, 6, 0, 16'h5000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            check(vecs[i].name, 64'(observe()), 64'(vecs[i].exp));
            tick();
        end

        // Halt must hold with frozen PC and no enables.
        halt_exp = vecs[19].exp;
        for (int i = 0; i < 20; i++) begin
            check("halt_hold", 64'(observe()), 64'(halt_exp));
            tick();
        end

        // ---------------- Store then Halt, PC_Out = 2 while halted ----------------
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1A80;
        rom[1] = 16'h5000;
        do_reset();
        repeat (3) tick();
        check("sh_store", 64'(observe()),
              64'(mk(4'h4, 1, 0, 16'h1A80, 8'h80, 1, 0, 0, 0, 4'hA, 0, 3'd0)));
        repeat (3) tick();
        for (int i = 0; i < 20; i++) begin
            check("sh_halt", 64'(observe()),
                  64'(mk(4'h9, 2, 0, 16'h5000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)));
            tick();
        end

        // ---------------- PC wrap over 129 NOOP fetches ----------------
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        do_reset();
        for (int k = 0; k < 129; k++) begin
            wait_state(4'h1, 6, ok);
            if (!ok) begin
                check("wrap_timeout", 64'(0), 64'(1));
                break;
            end
            check("wrap_fetch_pc", 64'(PC_Out), 64'(k % 128));
            tick();
            // Decode of the fetch at PC 127 must show the wrapped PC.
            if (k == 127) check("wrap_decode_pc", 64'(PC_Out), 64'(0));
        end

        // ---------------- Reset asserted during Store ----------------
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1A80;
        do_reset();
        wr_seen = 0;
        repeat (3) begin
            if (D_wr) wr_seen++;
            tick();
        end
        check("rst_store_state", 64'(OutState), 64'(4'h4));
        if (D_wr) wr_seen++;
        Reset = 1'b1;
        tick();
        check("rst_store_init", 64'(observe()),
              64'(mk(4'h0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)));
        if (D_wr) wr_seen++;
        Reset = 1'b0;
        tick();
        check("rst_store_fetch", 64'(observe()),
              64'(mk(4'h1, 0, 1, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)));
        check("rst_store_wr_once", 64'(wr_seen), 64'(1));

        // ---------------- Illegal opcode ----------------
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h7000;
        do_reset();
        repeat (3) tick();
`ifdef PCU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            check("illegal_trap", 64'(observe()),
                  64'(mk(4'hF, 1, 0, 16'h7000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)));
            tick();
        end
`else
        check("illegal_noop", 64'(observe()),
              64'(mk(4'h3, 1, 0, 16'h7000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)));
        tick();
        check("illegal_fetch", 64'(observe()),
              64'(mk(4'h1, 1, 1, 16'h7000, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time bound in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no end, expected finish");
        $fatal(1, "timeout");
    end

endmodule
